// File: rtl/peri_switches_pkg.sv
// Shared definitions for the switch event peripheral: register offsets, register
// selects and the address decoder.
// Optional timestamp register is enabled by the SW_TIMESTAMP_EN macro (see top).
package peri_switches_pkg;

   localparam logic [31:0] OFF_DATA   = 32'h00;
   localparam logic [31:0] OFF_RISE   = 32'h04;
   localparam logic [31:0] OFF_FALL   = 32'h08;
   localparam logic [31:0] OFF_MASK   = 32'h0C;
   localparam logic [31:0] OFF_TSTAMP = 32'h10;

   typedef enum logic [2:0] {
      RegData,
      RegRise,
      RegFall,
      RegMask,
      RegTstamp,
      RegNone
   } sw_reg_e;

   // Maps a word-aligned byte offset onto a register select
   function automatic sw_reg_e decode_reg(input logic [31:0] off);
      sw_reg_e sel;
      case (off)
         OFF_DATA:   sel = RegData;
         OFF_RISE:   sel = RegRise;
         OFF_FALL:   sel = RegFall;
         OFF_MASK:   sel = RegMask;
         OFF_TSTAMP: sel = RegTstamp;
         default:    sel = RegNone;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/detector_flancos.sv
// Per-bit rising/falling edge detector. The first clock after reset release only
// primes the history register, so switches already on at reset raise no event.
module detector_flancos
   import peri_switches_pkg::*;
#(
   parameter int unsigned N_SW = 16
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic [N_SW-1:0] switches_i,
   output logic [N_SW-1:0] rise_o,
   output logic [N_SW-1:0] fall_o
);

   logic [N_SW-1:0] prev_q;
   logic            primed_q;

   // History register and priming bit
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         prev_q   <= '0;
         primed_q <= 1'b0;
      end else begin
         prev_q   <= switches_i;
         primed_q <= 1'b1;
      end
   end

   // Edge events, suppressed until the history holds a real sample
   always_comb begin
      rise_o = '0;
      fall_o = '0;
      if (primed_q) begin
         rise_o = switches_i & ~prev_q;
         fall_o = ~switches_i & prev_q;
      end
   end

endmodule

// File: rtl/peri_switches_eventos.sv
// Switch event peripheral: edge detection into sticky W1C flags, per-switch irq mask,
// registered level interrupt and a small memory-mapped register window.
// Define SW_TIMESTAMP_EN to add a free-running cycle counter captured into TSTAMP (0x10)
// on any edge event; otherwise 0x10 is unmapped.
module peri_switches_eventos
   import peri_switches_pkg::*;
#(
   parameter int unsigned N_SW   = 16,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [N_SW-1:0]   switches_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              irq_o
);

   logic [N_SW-1:0] rise_evt;
   logic [N_SW-1:0] fall_evt;
   logic [N_SW-1:0] rise_q, rise_d;
   logic [N_SW-1:0] fall_q, fall_d;
   logic [N_SW-1:0] mask_q, mask_d;
   logic [N_SW-1:0] wdata_sw;
   logic [31:0]     rdata_q, rdata_d;
   logic [31:0]     off;
   logic            irq_q;
   sw_reg_e         sel;

   // Bits above N_SW and the byte lane bits of the address carry no meaning
   logic unused_bits;
   assign unused_bits = ^{wdata_i, addr_i[1:0]};

   detector_flancos #(
      .N_SW(N_SW)
   ) u_detector (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .switches_i(switches_i),
      .rise_o    (rise_evt),
      .fall_o    (fall_evt)
   );

`ifdef SW_TIMESTAMP_EN
   logic [31:0] cnt_q;
   logic [31:0] tstamp_q;

   // Free-running counter; one capture per cycle no matter how many bits toggled
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         cnt_q    <= '0;
         tstamp_q <= '0;
      end else begin
         cnt_q <= cnt_q + 32'd1;
         if (|(rise_evt | fall_evt)) begin
            tstamp_q <= cnt_q;
         end
      end
   end
`endif

   // Address decode; TSTAMP is only mapped when the counter exists
   always_comb begin
      off = 32'(addr_i) & ~32'h3;
      sel = decode_reg(off);
`ifdef SW_TIMESTAMP_EN
      if (sel == RegTstamp) begin
         sel = RegTstamp;
      end
`else
      if (sel == RegTstamp) begin
         sel = RegNone;
      end
`endif
   end

   // Flag and mask next state; an event on the cleared bit wins over the W1C
   always_comb begin
      wdata_sw = wdata_i[N_SW-1:0];
      rise_d   = (rise_q & ~((we_i && sel == RegRise) ? wdata_sw : '0)) | rise_evt;
      fall_d   = (fall_q & ~((we_i && sel == RegFall) ? wdata_sw : '0)) | fall_evt;
      mask_d   = (we_i && sel == RegMask) ? wdata_sw : mask_q;
   end

   // Read mux on current register values, so a same-cycle write returns old data
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         rdata_d = '0;
         unique case (sel)
            RegData: rdata_d[N_SW-1:0] = switches_i;
            RegRise: rdata_d[N_SW-1:0] = rise_q;
            RegFall: rdata_d[N_SW-1:0] = fall_q;
            RegMask: rdata_d[N_SW-1:0] = mask_q;
`ifdef SW_TIMESTAMP_EN
            RegTstamp: rdata_d = tstamp_q;
`else
            RegTstamp: rdata_d = '0;
`endif
            RegNone: rdata_d = '0;
            default: rdata_d = '0;
         endcase
      end
   end

   // State registers and the registered interrupt
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rise_q  <= '0;
         fall_q  <= '0;
         mask_q  <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         mask_q  <= mask_d;
         rdata_q <= rdata_d;
         irq_q   <= |((rise_q | fall_q) & mask_q);
      end
   end

   assign rdata_o = rdata_q;
   assign irq_o   = irq_q;

endmodule
